// File: rtl/count19_pkg.sv
// Shared types and defaults for the count19_ctrl stopwatch counter.
package count19_pkg;

  localparam int unsigned TICK_DIV_DEF  = 100;
  localparam int unsigned MAX_COUNT_DEF = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Two-digit BCD increment; ones rolls 9 -> 0 and carries into tens.
  function automatic bcd_t bcd_next(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a clk-synchronous key level.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic r_prev;

  // History resets high so a key held through reset release gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b1;
    else        r_prev <= d;
  end

  assign pulse = d & ~r_prev;

endmodule

// File: rtl/count19_ctrl.sv
// Start/pause/clear BCD counter 00..MAX_COUNT stepping once per TICK_DIV clocks.
module count19_ctrl
  import count19_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_btn,
  input  logic       clr_btn,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [3:0]  MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [3:0]  MAX_ONES  = 4'(MAX_COUNT % 10);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  bcd_t          r_cnt;
  logic          r_running;
  logic          r_wrap;

  logic w_run_pulse;
  logic w_clr_pulse;
  logic w_at_max;

  edge_rise u_run_edge (.clk(clk), .rst_n(rst_n), .d(run_btn), .pulse(w_run_pulse));
  edge_rise u_clr_edge (.clk(clk), .rst_n(rst_n), .d(clr_btn), .pulse(w_clr_pulse));

  assign w_at_max = (r_cnt.tens == MAX_TENS) && (r_cnt.ones == MAX_ONES);

  // Clear wins over run; a run edge in RUN pauses without consuming a prescaler tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_clr_pulse) begin
        r_state   <= IDLE;
        r_presc   <= '0;
        r_cnt     <= '0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_run_pulse) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (w_run_pulse) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else if (r_presc == PRE_TOP) begin
              r_presc <= '0;
              if (w_at_max) begin
                r_cnt  <= '0;
                r_wrap <= 1'b1;
              end else begin
                r_cnt <= bcd_next(r_cnt);
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          PAUSE: begin
            if (w_run_pulse) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tens    = r_cnt.tens;
  assign ones    = r_cnt.ones;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_count19_ctrl.sv
// Randomized and directed scoreboard bench for count19_ctrl against an integer reference model.
module tb_count19_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned MC = 19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_btn;
  logic       clr_btn;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       wrap;

  count19_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_btn (run_btn),
    .clr_btn (clr_btn),
    .tens    (tens),
    .ones    (ones),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit run;
    bit wrp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0=stopped at zero, 1=counting, 2=held.
  int m_mode;
  int m_count;
  int m_phase;
  bit m_prev_run;
  bit m_prev_clr;

  task automatic model_reset();
    m_mode     = 0;
    m_count    = 0;
    m_phase    = 0;
    m_prev_run = 1'b1;
    m_prev_clr = 1'b1;
  endtask

  // Called at a negedge: drive one cycle of keys, predict the next posedge, wait a cycle.
  task automatic step(input bit r, input bit c);
    exp_t e;
    bit   re, ce, w;
    run_btn = r;
    clr_btn = c;
    re = r && !m_prev_run;
    ce = c && !m_prev_clr;
    m_prev_run = r;
    m_prev_clr = c;
    w = 1'b0;
    if (ce) begin
      m_mode  = 0;
      m_count = 0;
      m_phase = 0;
    end else if (re) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      m_phase++;
      if (m_phase == int'(TD)) begin
        m_phase = 0;
        if (m_count == int'(MC)) begin
          m_count = 0;
          w = 1'b1;
        end else begin
          m_count++;
        end
      end
    end
    e.count = m_count;
    e.run   = (m_mode == 1);
    e.wrp   = w;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input int cnt, input bit r, input bit w);
    int act;
    act = int'(tens) * 10 + int'(ones);
    n_checks++;
    if (act != cnt || running !== r || wrap !== w) begin
      n_fail++;
      $display("FAIL %s: got count=%0d running=%b wrap=%b, want count=%0d running=%b wrap=%b",
               name, act, running, wrap, cnt, r, w);
    end
  endtask

  // Monitor: range invariants every cycle, scoreboard pop whenever a prediction is pending.
  always @(posedge clk) begin
    exp_t e;
    int   act;
    #1;
    act = int'(tens) * 10 + int'(ones);
    n_checks++;
    if (tens > 4'd1 || ones > 4'd9 || act > int'(MC)) begin
      n_fail++;
      $display("FAIL range: got tens=%0d ones=%0d, want tens<=1 ones<=9 value<=%0d",
               tens, ones, MC);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (act != e.count || running !== e.run || wrap !== e.wrp) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got count=%0d running=%b wrap=%b, want count=%0d running=%b wrap=%b",
                 $time, act, running, wrap, e.count, e.run, e.wrp);
      end
    end
  end

  initial begin
    bit r;
    bit c;
    rst_n   = 1'b0;
    run_btn = 1'b0;
    clr_btn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_now("reset_state", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Full sweep to MAX_COUNT and rollover.
    step(1'b1, 1'b0);
    for (int i = 1; i <= 81; i++) begin
      step(1'b1, 1'b0);
      if (i == 4)  check_now("first_step", 1, 1'b1, 1'b0);
      if (i == 76) check_now("reach_max", int'(MC), 1'b1, 1'b0);
      if (i == 80) check_now("wrap_pulse", 0, 1'b1, 1'b1);
      if (i == 81) check_now("wrap_one_cycle", 0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1);
    check_now("clear_from_run", 0, 1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Pause keeps partial prescaler period.
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_now("paused_at_01", 1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    check_now("pause_holds", 1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_now("resumed", 1, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_now("resume_plus2", 1, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_now("resume_plus3", 2, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Simultaneous clear and run edges at count 07.
    step(1'b1, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b0);
    check_now("count_07", 7, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_now("clear_beats_run", 0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    check_now("held_keys_idle", 0, 1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Held run key: single transition only.
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0);
    check_now("held_run_still_running", m_count, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Async reset mid-count with run held through release.
    step(1'b1, 1'b0);
    for (int i = 0; i < 52; i++) step(1'b1, 1'b0);
    check_now("count_13", 13, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_now("async_reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check_now("idle_after_reset", 0, 1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Randomized key activity.
    r = 1'b0;
    c = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) r = ~r;
      c = ($urandom_range(0, 79) == 0);
      step(r, c);
    end
    step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count19_ctrl.md
COUNT19_CTRL -- requirements
Module: count19_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100, meaning clk cycles per count step (100 Hz clk gives 1 Hz stepping); legal range 2..255.
REQ-002 The block SHALL have parameter MAX_COUNT, default 19, meaning the terminal count; legal range 1..99.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL run on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-005 The block SHALL have port run_btn, input, 1 bit: the debounced start/pause key level, clk-synchronous.
REQ-006 The block SHALL have port clr_btn, input, 1 bit: the debounced clear key level, clk-synchronous.
REQ-007 The block SHALL have port tens, output, 4 bits: the BCD tens digit of the count.
REQ-008 The block SHALL have port ones, output, 4 bits: the BCD ones digit of the count.
REQ-009 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-010 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on MAX_COUNT->0 rollover.

Function
REQ-011 The block SHALL detect rising edges of run_btn and clr_btn by comparing each input with its value registered one cycle earlier.
REQ-012 The FSM SHALL have exactly three states: IDLE (count 0, stopped), RUN, and PAUSE (count held).
REQ-013 A run_btn edge SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN; running SHALL update in the cycle after the edge is sampled.
REQ-014 A clr_btn edge in any state SHALL go to IDLE and set the count to 00 and the prescaler to 0 in the next cycle.
REQ-015 A clr_btn edge and a run_btn edge in the same cycle SHALL resolve as clear: the result SHALL be state IDLE with running=0.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, and SHALL hold its value in PAUSE so that a resume continues the partial period.
REQ-017 When the prescaler equals TICK_DIV-1 in RUN, it SHALL return to 0 and the count SHALL advance by one in the same cycle.
REQ-018 The count SHALL be held as two BCD digits; ones=9 SHALL roll to 0 and increment tens; no digit SHALL ever exceed 9.
REQ-019 Advancing from MAX_COUNT SHALL load 00 and assert wrap for exactly that one cycle; the state SHALL remain RUN.
REQ-020 A key held continuously SHALL produce one edge only; holding a level SHALL have no further effect.
REQ-021 tens, ones, running and wrap SHALL be registered outputs with no combinational path from any input.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, tens=0, ones=0, running=0, wrap=0 and prescaler=0.
REQ-023 The edge-detect history registers SHALL reset to 1, so that a key held through reset release produces no edge.
REQ-024 Reset asserted mid-count SHALL discard all progress; after release the block SHALL wait in IDLE for a run_btn edge.

Structure
REQ-025 Package count19_pkg SHALL hold the state enumeration (IDLE, RUN, PAUSE) and the TICK_DIV and MAX_COUNT defaults.
REQ-026 Rising-edge detection SHALL be a sub-module, edge_rise (ports clk, rst_n, d, pulse), instantiated once per key.
REQ-027 The prescaler width SHALL be derived as clog2(TICK_DIV).

Verification
REQ-028 TICK_DIV=4: reset, one run_btn edge, 80 clk -> count reaches 19 at cycle 76; 00 at cycle 80 with wrap high for that cycle only.
REQ-029 TICK_DIV=4: run, pause after 6 clk (count 01, prescaler 1), wait 20 clk, resume -> count 02 exactly 3 clk after resume; the count holds during the pause.
REQ-030 clr_btn and run_btn rising in the same cycle while in RUN at count 07 -> next cycle count 00, running 0, state IDLE.
REQ-031 run_btn held high for 500 clk -> exactly one transition (IDLE->RUN); no toggling afterward.
REQ-032 rst_n pulsed low mid-count at 13 (asynchronous, between edges), run_btn held high through release -> outputs 00/0/0 immediately, block stays IDLE.
REQ-033 The bench SHALL check continuously, for all scenarios, that tens<=1, ones<=9 and the value never exceeds MAX_COUNT.
